// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch stage with one-cycle IM, DEPTH-entry prefetch FIFO,
// fetch-time folding of B/BR and flush on ID redirect.
module if_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               write_enable,
  input  logic [2:0]         write_addr,
  input  logic [31:0]        write_value,
  output logic [2:0]         br_addr,
  input  logic [31:0]        br_value,
  output logic [ADDR_W-1:0]  fetch_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, off, target, nxt_pc;
  logic inflight_q, inflight_d, squash_q, squash_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [31:0] base;
  logic is_b, is_br, resp_ok, take_br, push, pop;
  always_comb begin
    br_addr = im_data[24:22];
    is_b = im_data[31:25] == 7'b1100000;
    is_br = im_data[31:25] == 7'b1100010;
    resp_ok = inflight_q && !squash_q;
    take_br = resp_ok && (is_b || is_br) && !redirect_en;
    off = ADDR_W'($signed(im_data[15:0])) << 2;
    base = (write_enable && write_addr == br_addr) ? write_value : br_value;
    target = (is_br ? ADDR_W'(base) : resp_pc_q) + off;
    im_req = !rst && ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    id_valid = count_q != '0;
    push = resp_ok && !(is_b || is_br) && !redirect_en;
    pop = id_valid && id_ready && !redirect_en;
    nxt_pc = redirect_en ? redirect_pc : take_br ? target : im_req ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    fetch_pc_d = nxt_pc & ~ADDR_W'(3);
    inflight_d = im_req;
    // the request issued alongside a redirect or a folded branch is on the wrong path
    squash_d = im_req && (redirect_en || take_br);
    resp_pc_d = im_req ? fetch_pc_q : resp_pc_q;
    count_d = redirect_en ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = redirect_en ? rd_ptr_q : wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // when empty, the slot behind rd_ptr still holds the last popped entry
    head = (count_q == '0) ? rd_ptr_q - PW'(1) : rd_ptr_q;
    id_instr = instr_q[head];
    id_pc = pc_q[head];
    im_addr = fetch_pc_q;
    fetch_pc = fetch_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q <= 1'b0;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      inflight_q <= inflight_d;
      squash_q <= squash_d;
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= im_data;
      pc_q[wr_ptr_q] <= resp_pc_q;
    end
  end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Parametrised next-generation instruction fetch stage. It keeps a fetch PC and issues requests to Instruction Memory (IM), which has a fixed one-cycle read latency. Returned words are buffered in a DEPTH-entry FIFO with their PCs and handed to ID over a valid/ready handshake. Unconditional B/BR branches are folded at fetch and never enqueued; conditional redirects from ID flush the queue.

Parameters:
ADDR_W, 32, PC/IM address width
INSTR_W, 32, instruction width (>=32)
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
im_req  out  1  IM read request this cycle
im_addr  out  ADDR_W  IM byte address (= fetch_pc)
im_data  in  INSTR_W  IM data, valid the cycle after an accepted im_req
id_valid  out  1  FIFO head valid
id_ready  in  1  ID accepts head
id_instr  out  INSTR_W  head instruction
id_pc  out  ADDR_W  head PC
redirect_en  in  1  ID-resolved branch taken; flush
redirect_pc  in  ADDR_W  new fetch PC
write_enable  in  1  register-file write this cycle (forwarding)
write_addr  in  3  register being written
write_value  in  32  value being written
br_addr  out  3  register index for BR (combinational from im_data[24:22])
br_value  in  32  register-file read of br_addr
fetch_pc  out  ADDR_W  current fetch PC

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC; FIFO empty; inflight=0; squash=0; im_req=0 while rst is high; id_valid=0. A reset mid-operation discards everything, including any in-flight response.
- Issue: im_req = !rst && (count + inflight < DEPTH). An accepted request sets inflight=1 and fetch_pc += 4. inflight clears the next cycle, when im_data is sampled.
- Response handling, in the cycle inflight=1 and squash=0:
  - opcode = im_data[31:25].
  - off = sign_extend(im_data[15:0]) << 2, truncated to ADDR_W.
  - 7'b1100000 (B): fetch_pc <= resp_pc + off. Not enqueued. Set squash for the next-cycle response, because the speculatively issued resp_pc+4 request is in flight.
  - 7'b1100010 (BR): base = (write_enable && write_addr==br_addr) ? write_value : br_value. fetch_pc <= base + off. Not enqueued. Squash as for B.
  - Any other opcode: enqueue {im_data, resp_pc}.
  - resp_pc is the registered address of the request being returned.
- A squashed response is dropped and squash clears. Branch targets need not be word-aligned; bits [1:0] of fetch_pc are forced to 0.
- Dequeue: a pop occurs when id_valid && id_ready. id_instr and id_pc show the head entry combinationally; when empty they hold their last value.
- Simultaneous push and pop: both happen and count is unchanged. A push when full cannot occur, because the issue rule guarantees space.
- redirect_en has priority over everything:
  - fetch_pc <= redirect_pc & ~3.
  - FIFO cleared (count=0) and any same-cycle pop or push is ignored.
  - Any request in flight is marked squashed.
  - A fetch-stage branch in the same cycle is ignored.
  - im_req in the redirect cycle is still issued, but its response is squashed. The first useful request to redirect_pc goes out the following cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Latency: reset release to first id_valid is 2 cycles. A taken B/BR costs 1 bubble. A redirect yields its first id_valid 2 cycles later.

Test Plan:
- Straight-line: reset with RESET_PC=0, IM holds non-branch words, id_ready=1 -> id_pc sequence 0,4,8,12…; id_valid first high 2 cycles after reset release; no gaps.
- Backpressure: id_ready=0 for 10 cycles -> exactly DEPTH=4 entries queued, im_req drops to 0, no entry lost or duplicated. id_ready=1 -> PCs 0,4,8,12,16 in order.
- B fold: word at 0x8 is B with imm=0xFFFE -> 0x8 never reaches ID; word at 0xC is squashed; next id_pc is 0x0.
- BR with forwarding: BR r3, imm=1 at 0x4; same cycle write_enable=1, write_addr=3, write_value=0x100, br_value=0x50 -> next fetch_pc=0x104.
- Redirect: queue holds 3 entries; redirect_en=1, redirect_pc=0x200, with a B returning the same cycle -> queue empty next cycle; B ignored; next id_pc is 0x200.
- Reset mid-run: rst asserted while the queue is full and a request is in flight -> id_valid=0, im_req=0 during reset; restart at RESET_PC with the stale response dropped.
